// File: rtl/sc_corr_sng_if.sv
// Load handshake and stream output bundle for the correlated stochastic number generator.
interface sc_corr_sng_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             hold;
  logic             bit_valid;
  logic             bit_a;
  logic             bit_b;
  logic             bit_last;

  modport master (
    output in_valid, in_a, in_b, hold,
    input  in_ready, bit_valid, bit_a, bit_b, bit_last
  );

  modport slave (
    input  in_valid, in_a, in_b, hold,
    output in_ready, bit_valid, bit_a, bit_b, bit_last
  );
endinterface

// File: rtl/sc_corr_sng.sv
// Correlated stochastic number generator: two unipolar streams compared against one shared
// Galois LFSR, giving maximally positively correlated bitstreams of length 2^WIDTH-1.
module sc_corr_sng #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01)
) (
  input  logic         clk,
  input  logic         rst,
  sc_corr_sng_if.slave bus
);

  localparam logic [WIDTH-1:0] LAST_CNT = {{(WIDTH-1){1'b1}}, 1'b0};

  // An all-zero seed would lock the LFSR at zero.
  generate
    if (SEED == '0) begin : g_bad_seed
      $error("sc_corr_sng: SEED must be nonzero");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] cnt;

  logic             run_c;
  logic             valid_c;
  logic             last_c;
  logic             ready_c;
  logic             xfer_c;
  logic [WIDTH-1:0] lfsr_next_c;

  assign run_c       = (state == RUN);
  assign valid_c     = run_c && !bus.hold;
  assign last_c      = valid_c && (cnt == LAST_CNT);
  assign ready_c     = !rst && (!run_c || last_c);
  assign xfer_c      = bus.in_valid && ready_c;
  assign lfsr_next_c = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

  // Both streams compare against the same LFSR value in the same cycle.
  assign bus.in_ready  = ready_c;
  assign bus.bit_valid = valid_c;
  assign bus.bit_a     = valid_c && (lfsr <= a_reg);
  assign bus.bit_b     = valid_c && (lfsr <= b_reg);
  assign bus.bit_last  = last_c;

  // A new load on the last-bit cycle takes priority over returning to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      cnt   <= '0;
      lfsr  <= SEED;
    end else if (xfer_c) begin
      state <= RUN;
      a_reg <= bus.in_a;
      b_reg <= bus.in_b;
      cnt   <= '0;
      lfsr  <= SEED;
    end else if (valid_c) begin
      lfsr <= lfsr_next_c;
      cnt  <= cnt + WIDTH'(1);
      if (last_c) state <= IDLE;
    end
  end

endmodule

// File: tb/tb_sc_corr_sng.sv
// Randomized self-checking bench for sc_corr_sng against a stream-level reference model.
module tb_sc_corr_sng;
  localparam int N = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sc_corr_sng_if #(.WIDTH(8)) bus ();
  sc_corr_sng dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int seq[N];
  bit qa[$];
  bit qb[$];
  int ones_a, ones_b, nbits, holds, cycles, lasts, bad_corr, bad_seq, bad_valid, bad_lh;
  bit rdy_at_last;

  // Random-source order derived from the Galois recurrence starting at the seed.
  function automatic void build_seq();
    int v = 1;
    for (int i = 0; i < N; i++) begin
      seq[i] = v;
      v = ((v & 1) != 0) ? ((v >> 1) ^ 'hB8) : (v >> 1);
    end
  endfunction

  task automatic load(input int a, input int b);
    @(negedge clk);
    rst = 1'b0; bus.hold = 1'b0; bus.in_valid = 1'b1;
    bus.in_a = 8'(a); bus.in_b = 8'(b);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1", bus.in_ready); end
    @(posedge clk);
  endtask

  // Observes one stream; optionally holds, injects ignored loads, or chains the next pair.
  task automatic collect(input int a, input int b, input int hold_pct, input int hold_last,
                         input int stop_after, input bit noise, input bit chain,
                         input int na, input int nb);
    bit h;
    bit done = 1'b0;
    int hl = hold_last;
    ones_a = 0; ones_b = 0; nbits = 0; holds = 0; cycles = 0; lasts = 0;
    bad_corr = 0; bad_seq = 0; bad_valid = 0; bad_lh = 0; rdy_at_last = 1'b0;
    qa.delete(); qb.delete();
    while (!done) begin
      @(negedge clk);
      h = ($urandom_range(0, 99) < hold_pct);
      if (nbits == N-1 && hl > 0) begin h = 1'b1; hl--; end
      bus.hold = h;
      if (noise && nbits < N-5) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
      end else bus.in_valid = 1'b0;
      #1;
      cycles++;
      if (h) holds++;
      if (bus.bit_valid !== !h) bad_valid++;
      if (nbits == N-1 && h && (bus.bit_last !== 1'b0 || bus.in_ready !== 1'b0)) bad_lh++;
      if (bus.bit_valid === 1'b1) begin
        qa.push_back(bus.bit_a); qb.push_back(bus.bit_b);
        ones_a += int'(bus.bit_a); ones_b += int'(bus.bit_b);
        if (nbits >= N || bus.bit_a !== (seq[nbits] <= a) || bus.bit_b !== (seq[nbits] <= b)) bad_seq++;
        if (bus.bit_a === 1'b1 && bus.bit_b === 1'b0) bad_corr++;
        if (bus.bit_last === 1'b1) begin
          lasts++; done = 1'b1; rdy_at_last = bus.in_ready;
          if (chain) begin bus.in_valid = 1'b1; bus.in_a = 8'(na); bus.in_b = 8'(nb); end
        end
        nbits++;
        if (nbits == stop_after) done = 1'b1;
      end
      if (cycles >= 2000) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b1; bus.hold = 1'b0; bus.in_a = 8'h12; bus.in_b = 8'h34;
    repeat (3) begin
      @(negedge clk); #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.bit_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_active: in_ready=%b bit_valid=%b want 0 0", bus.in_ready, bus.bit_valid);
      end
    end
    @(negedge clk); rst = 1'b0; bus.in_valid = 1'b0; bus.hold = 1'b1; #1;
    n_checks++;
    if ({bus.in_ready, bus.bit_valid, bus.bit_a, bus.bit_b, bus.bit_last} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_idle: rdy/v/a/b/last=%b%b%b%b%b want 10000",
                         bus.in_ready, bus.bit_valid, bus.bit_a, bus.bit_b, bus.bit_last);
    end
    bus.hold = 1'b0;
  endtask

  task automatic test_basic();
    bit exp_a[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit g;
    load(8'h80, 8'hFF);
    collect(8'h80, 8'hFF, 0, 0, N, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      g = (i < qa.size()) ? qa[i] : ~exp_a[i];
      n_checks++;
      if (g !== exp_a[i]) begin n_fail++; $display("FAIL basic_bit_a[%0d]: got %b want %b", i, g, exp_a[i]); end
    end
    n_checks++; if (ones_a != 128) begin n_fail++; $display("FAIL basic_ones_a: got %0d want 128", ones_a); end
    n_checks++; if (ones_b != 255) begin n_fail++; $display("FAIL basic_ones_b: got %0d want 255", ones_b); end
    n_checks++; if (nbits != N || lasts != 1) begin n_fail++; $display("FAIL basic_len: bits=%0d lasts=%0d want 255 1", nbits, lasts); end
    n_checks++; if (bad_seq != 0) begin n_fail++; $display("FAIL basic_seq: got %0d bad bits want 0", bad_seq); end
    n_checks++; if (cycles != N) begin n_fail++; $display("FAIL basic_cycles: got %0d want 255", cycles); end
    n_checks++; if (rdy_at_last !== 1'b1) begin n_fail++; $display("FAIL basic_ready_last: got %b want 1", rdy_at_last); end
    @(negedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.bit_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_after: in_ready=%b bit_valid=%b want 1 0", bus.in_ready, bus.bit_valid);
    end
  endtask

  task automatic test_extremes();
    int pa[2] = '{0, 255};
    int pb[2] = '{255, 0};
    for (int k = 0; k < 2; k++) begin
      load(pa[k], pb[k]);
      collect(pa[k], pb[k], 0, 0, N, 1'b0, 1'b0, 0, 0);
      n_checks++;
      if (ones_a != pa[k] || ones_b != pb[k] || nbits != N) begin
        n_fail++; $display("FAIL extreme_%0d: ones a/b=%0d/%0d bits=%0d want %0d/%0d/255", k, ones_a, ones_b, nbits, pa[k], pb[k]);
      end
    end
  endtask

  task automatic test_corr();
    int a, b;
    for (int s = 0; s < 50; s++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(a, 255);
      load(a, b);
      collect(a, b, 0, 0, N, 1'b0, 1'b0, 0, 0);
      n_checks++; if (ones_a != a) begin n_fail++; $display("FAIL corr_ones_a: got %0d want %0d", ones_a, a); end
      n_checks++; if (ones_b != b) begin n_fail++; $display("FAIL corr_ones_b: got %0d want %0d", ones_b, b); end
      n_checks++; if (bad_corr != 0) begin n_fail++; $display("FAIL corr_a_not_b: got %0d bits want 0", bad_corr); end
      n_checks++; if (bad_seq != 0) begin n_fail++; $display("FAIL corr_seq: got %0d bad bits want 0", bad_seq); end
    end
  endtask

  task automatic test_back_to_back();
    int a1 = $urandom_range(0, 255);
    int b1 = $urandom_range(0, 255);
    int a2 = $urandom_range(0, 255);
    int b2 = $urandom_range(0, 255);
    load(a1, b1);
    collect(a1, b1, 0, 0, N, 1'b0, 1'b1, a2, b2);
    n_checks++; if (rdy_at_last !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", rdy_at_last); end
    n_checks++; if (ones_a != a1 || ones_b != b1) begin n_fail++; $display("FAIL b2b_first: got %0d/%0d want %0d/%0d", ones_a, ones_b, a1, b1); end
    collect(a2, b2, 0, 0, N, 1'b0, 1'b0, 0, 0);
    n_checks++; if (cycles != N || bad_valid != 0) begin n_fail++; $display("FAIL b2b_gap: cycles=%0d gaps=%0d want 255 0", cycles, bad_valid); end
    n_checks++; if (ones_a != a2 || ones_b != b2) begin n_fail++; $display("FAIL b2b_second: got %0d/%0d want %0d/%0d", ones_a, ones_b, a2, b2); end
    n_checks++; if (bad_seq != 0) begin n_fail++; $display("FAIL b2b_seq: got %0d bad bits want 0", bad_seq); end
  endtask

  task automatic test_hold();
    int a = $urandom_range(0, 255);
    int b = $urandom_range(0, 255);
    load(a, b);
    collect(a, b, 30, 0, N, 1'b0, 1'b0, 0, 0);
    n_checks++; if (ones_a != a || ones_b != b) begin n_fail++; $display("FAIL hold_ones: got %0d/%0d want %0d/%0d", ones_a, ones_b, a, b); end
    n_checks++; if (bad_valid != 0) begin n_fail++; $display("FAIL hold_valid: got %0d wrong cycles want 0", bad_valid); end
    n_checks++; if (cycles != N + holds) begin n_fail++; $display("FAIL hold_duration: got %0d want %0d", cycles, N + holds); end
    n_checks++; if (bad_seq != 0) begin n_fail++; $display("FAIL hold_seq: got %0d bad bits want 0", bad_seq); end
  endtask

  task automatic test_hold_last();
    int a = $urandom_range(0, 255);
    int b = $urandom_range(0, 255);
    load(a, b);
    collect(a, b, 0, 4, N, 1'b0, 1'b0, 0, 0);
    n_checks++; if (bad_lh != 0) begin n_fail++; $display("FAIL hold_last_leak: got %0d cycles want 0", bad_lh); end
    n_checks++; if (lasts != 1 || nbits != N) begin n_fail++; $display("FAIL hold_last_len: lasts=%0d bits=%0d want 1 255", lasts, nbits); end
    n_checks++; if (cycles != N + 4) begin n_fail++; $display("FAIL hold_last_duration: got %0d want %0d", cycles, N + 4); end
    n_checks++; if (rdy_at_last !== 1'b1) begin n_fail++; $display("FAIL hold_last_ready: got %b want 1", rdy_at_last); end
  endtask

  task automatic test_reset_mid();
    int a = $urandom_range(0, 255);
    int b = $urandom_range(0, 255);
    int c = $urandom_range(0, 255);
    int d = $urandom_range(0, 255);
    load(a, b);
    collect(a, b, 0, 0, 100, 1'b0, 1'b0, 0, 0);
    n_checks++; if (nbits != 100 || lasts != 0) begin n_fail++; $display("FAIL abort_prefix: bits=%0d lasts=%0d want 100 0", nbits, lasts); end
    @(negedge clk); rst = 1'b1; bus.hold = 1'b0; bus.in_valid = 1'b0; #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_in_rst: got %b want 0", bus.in_ready); end
    @(negedge clk); rst = 1'b0; #1;
    n_checks++;
    if (bus.bit_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.bit_last !== 1'b0) begin
      n_fail++; $display("FAIL abort_after: valid=%b ready=%b last=%b want 0 1 0", bus.bit_valid, bus.in_ready, bus.bit_last);
    end
    load(c, d);
    collect(c, d, 0, 0, N, 1'b1, 1'b0, 0, 0);
    n_checks++; if (ones_a != c || ones_b != d) begin n_fail++; $display("FAIL abort_reload_ones: got %0d/%0d want %0d/%0d", ones_a, ones_b, c, d); end
    n_checks++; if (nbits != N || lasts != 1) begin n_fail++; $display("FAIL abort_reload_len: bits=%0d lasts=%0d want 255 1", nbits, lasts); end
    n_checks++; if (bad_seq != 0) begin n_fail++; $display("FAIL abort_reload_seq: got %0d bad bits want 0", bad_seq); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.hold = 1'b0; bus.in_a = '0; bus.in_b = '0;
    build_seq();
    test_reset();
    test_basic();
    test_extremes();
    test_corr();
    test_back_to_back();
    test_hold();
    test_hold_last();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sc_corr_sng.md
# sc_corr_sng

Correlated stochastic number generator: encodes two unsigned binary operands into a pair of maximally positively correlated unipolar bitstreams. Both streams are generated against one shared LFSR random source. It is the transmit end of our stochastic divider datapath: its two streams drive the divider's dividend and divisor inputs, which require positive correlation for accurate division. Each accepted operand pair produces exactly one stream of 2^WIDTH−1 bits, with a valid/ready load handshake and a hold input for back-pressure.

## Interface
- WIDTH, 8: operand and LFSR width. Stream length is N = 2^WIDTH−1.
- TAPS, 8'hB8: Galois LFSR feedback mask. Must be maximal-length for WIDTH.
- SEED, 8'h01: LFSR value loaded at each stream start. Must be nonzero; elaboration fails on 0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept a pair this cycle.
- in_a  in  WIDTH  operand A (e.g. dividend), value a/N.
- in_b  in  WIDTH  operand B (e.g. divisor), value b/N.
- hold  in  1  freeze the stream; no bit is emitted while high.
- bit_valid  out  1  bit_a/bit_b are valid this cycle.
- bit_a  out  1  stream bit for A.
- bit_b  out  1  stream bit for B.
- bit_last  out  1  final bit (index N−1) of the current stream.

## Operation
- State registers:
  - FSM {IDLE, RUN}.
  - a_reg, b_reg (WIDTH).
  - lfsr (WIDTH).
  - cnt (WIDTH), counting 0..N−1.
- Handshake: a transfer occurs on a rising edge where in_valid && in_ready.
  - On transfer: a_reg←in_a, b_reg←in_b, lfsr←SEED, cnt←0, state←RUN.
  - in_a/in_b are sampled only on a transfer. in_valid without in_ready is ignored, with no side effects.
- in_ready = !rst && (state==IDLE || (bit_valid && bit_last)). This permits back-to-back streams with no gap.
- In RUN:
  - bit_valid = !hold.
  - bit_a = (lfsr <= a_reg).
  - bit_b = (lfsr <= b_reg).
  - bit_last = bit_valid && (cnt == N−1).
  - Comparison is unsigned. Both outputs use the same lfsr value in the same cycle, giving maximal positive correlation.
- Advance (RUN && !hold):
  - lfsr ← lfsr[0] ? (lfsr>>1) ^ TAPS : lfsr>>1.
  - cnt ← cnt+1.
  - On the last bit: state←IDLE, unless a transfer occurs in the same cycle, in which case the new load wins and state stays RUN.
- Hold in RUN: lfsr, cnt and state are frozen, and bit_valid=bit_a=bit_b=bit_last=0.
- Hold in IDLE has no effect.
- In IDLE: bit_valid, bit_a, bit_b and bit_last are all 0.
- Stream counts: lfsr visits every nonzero value exactly once per stream. Ones in stream A = a_reg exactly, and likewise for B.
  - Operand 0 gives an all-zero stream.
  - Operand N gives an all-one stream.
  - Whenever a_reg ≤ b_reg, bit_a=1 implies bit_b=1 on every bit.

## Timing
- Reset: while rst is high (sampled at edge), state←IDLE and a_reg, b_reg, cnt←0, lfsr←SEED.
  - Outputs during and after reset until a transfer: in_ready=0 while rst=1, then 1. bit_valid=bit_a=bit_b=bit_last=0.
- Reset mid-stream aborts the stream immediately. No bit_last is emitted for the aborted stream.
- Latency: transfer at edge k gives the first bit (lfsr=SEED) valid in cycle k+1, when hold=0.
- Stream duration: N cycles plus the number of hold cycles.
- Outputs are combinational from registered state, a_reg/b_reg and hold. There is no combinational path from in_valid/in_a/in_b to any output except in_ready (which depends on hold).
- Last bit under hold: if hold is high when cnt==N−1, no bit and no in_ready are produced. The last bit is emitted on the first non-hold cycle.

## Test plan
- Reset then load a=0x80, b=0xFF (defaults):
  - First six bits: lfsr 01,B8,5C,2E,17,B3 → bit_a 1,0,1,1,1,0 and bit_b all 1.
  - Totals over 255 bits: A=128 ones, B=255 ones.
  - bit_last only on bit 255, then in_ready=1.
- a=0x00, b=0xFF → bit_a 0 for all 255 bits, bit_b 1 for all. a=0xFF, b=0x00 → the converse.
- Correlation check, random pairs with a≤b, 50 streams:
  - Ones counts exactly a and b.
  - Never bit_a=1 && bit_b=0.
- Back-to-back: hold in_valid high with a new pair on the last-bit cycle.
  - Next cycle starts the new stream at lfsr=0x01 with no gap.
  - Total ones for the new stream match the new operands.
- Hold:
  - Random 30% hold during a stream → counts unchanged. bit_valid is low exactly on hold cycles, and duration is 255 + hold count.
  - Hold high at cnt=254 → no bit_last and in_ready=0 until hold drops.
- Reset at bit 100 of a stream:
  - Next cycle: bit_valid=0 and in_ready=1.
  - A new load gives a full 255-bit stream with the correct counts.
  - in_valid while in_ready=0 mid-stream does not change the operands.
